mecanismo_flipping_pipeline: RTL and testbench

- Parametrised, handshaked successor of the registered flipping stage: M lanes of N-bit activations; each lane is conditionally bit-inverted and travels with its flip bit f.
- f comes from one of four modes per beat: bypass, external f bits, automatic bus-invert against the previous lane output, or automatic ones-minimisation.
- Sits between the activation buffer and the MAC array.
- Two-stage valid/ready pipeline with per-lane history and a saturating flip counter for switching-activity statistics.

---
 rtl/mecanismo_flipping_if.sv | 29 ++
 rtl/mecanismo_flipping_pipeline.sv | 149 ++++++++++++++
 tb/tb_mecanismo_flipping_pipeline.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mecanismo_flipping_if.sv
// Handshake and data bus of the flipping pipeline: an input beat of M lanes
// plus mode and external flip bits, and the output beat of processed lanes
// with the flip bit applied to each lane.
interface mecanismo_flipping_if #(
  parameter int N = 16,
  parameter int M = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   mode;
  logic [M-1:0] input_f_bits;
  logic [N-1:0] input_activaciones [M-1:0];
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] salida_activaciones [M-1:0];
  logic [M-1:0] salida_f_bits;

  // Producer/consumer side (activation buffer feeding, MAC array draining)
  modport master (
    output in_valid, mode, input_f_bits, input_activaciones, out_ready,
    input  in_ready, out_valid, salida_activaciones, salida_f_bits
  );

  // Pipeline side
  modport slave (
    input  in_valid, mode, input_f_bits, input_activaciones, out_ready,
    output in_ready, out_valid, salida_activaciones, salida_f_bits
  );
endinterface

// File: rtl/mecanismo_flipping_pipeline.sv
// Two-stage valid/ready flipping pipeline. S1 captures a beat of M lanes;
// S2 decides a flip bit per lane (bypass, external, bus-invert, ones-min),
// registers the conditionally inverted lanes and counts flipped lanes.

// One lane of S2: flip decision plus the output/history register.
// The registered output y is exactly the last processed value loaded into
// this lane, so it doubles as the bus-invert history.
module mecanismo_flipping_lane #(
  parameter int N      = 16,
  parameter int THRESH = N / 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [1:0]   mode,
  input  logic         f_ext,
  input  logic [N-1:0] a,
  output logic         f_next,
  output logic [N-1:0] y,
  output logic         f
);
  localparam int            PW = $clog2(N + 1);
  localparam logic [PW-1:0] TH = PW'(THRESH);

  logic [N-1:0]  metric_src;
  logic [PW-1:0] pc;

  // Metric is Hamming distance to history in bus-invert, ones count otherwise;
  // a metric equal to the threshold never flips.
  always_comb begin
    metric_src = (mode == 2'b10) ? (a ^ y) : a;
    pc = '0;
    for (int k = 0; k < N; k++) pc = pc + PW'(metric_src[k]);
    f_next = 1'b0;
    case (mode)
      2'b00:   f_next = 1'b0;
      2'b01:   f_next = f_ext;
      default: f_next = (pc > TH);
    endcase
  end

  // Output/history register: loads only on S2 load, holds during stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      y <= '0;
      f <= 1'b0;
    end else if (load) begin
      y <= a ^ {N{f_next}};
      f <= f_next;
    end
  end
endmodule

module mecanismo_flipping_pipeline #(
  parameter int N      = 16,
  parameter int M      = 16,
  parameter int THRESH = N / 2,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  mecanismo_flipping_if.slave  bus,
  input  logic                 clear_count,
  output logic [CNT_W-1:0]     flip_count
);
  localparam int STAGES = 2;
  localparam int FW     = $clog2(M + 1);
  localparam int SUMW   = ((CNT_W > FW) ? CNT_W : FW) + 1;
  localparam logic [SUMW-1:0] CNT_MAX = SUMW'({CNT_W{1'b1}});

  // vld_pipe[1] = S1 holds a beat, vld_pipe[2] = S2 output valid
  logic [STAGES:1] vld_pipe;
  logic            accept;
  logic            s1_adv;

  logic [N-1:0]    s1_a [M-1:0];
  logic [M-1:0]    s1_f;
  logic [1:0]      s1_mode;

  logic [M-1:0]    f_next;
  logic [N-1:0]    lane_y [M-1:0];
  logic [M-1:0]    lane_f;
  logic [FW-1:0]   f_pop;
  logic [SUMW-1:0] cnt_sum;

  // S1 moves into S2 whenever S2 is empty or being drained this cycle;
  // in_ready never looks at in_valid, and stays low while in reset.
  assign s1_adv       = vld_pipe[1] && (!vld_pipe[STAGES] || bus.out_ready);
  assign bus.in_ready = !rst && (!vld_pipe[1] || s1_adv);
  assign accept       = bus.in_valid && bus.in_ready;

  // Valid bits: reset discards any in-flight beat
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      if (accept)      vld_pipe[1] <= 1'b1;
      else if (s1_adv) vld_pipe[1] <= 1'b0;
      if (s1_adv)             vld_pipe[STAGES] <= 1'b1;
      else if (bus.out_ready) vld_pipe[STAGES] <= 1'b0;
    end
  end

  // S1 capture registers; contents are qualified by vld_pipe[1]
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a    <= bus.input_activaciones;
      s1_f    <= bus.input_f_bits;
      s1_mode <= bus.mode;
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_lane
    mecanismo_flipping_lane #(.N(N), .THRESH(THRESH)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .load   (s1_adv),
      .mode   (s1_mode),
      .f_ext  (s1_f[i]),
      .a      (s1_a[i]),
      .f_next (f_next[i]),
      .y      (lane_y[i]),
      .f      (lane_f[i])
    );
  end

  assign bus.out_valid           = vld_pipe[STAGES];
  assign bus.salida_activaciones = lane_y;
  assign bus.salida_f_bits       = lane_f;

  // Number of lanes flipping on this load, added in a widened sum so
  // saturation is detected even when M exceeds the counter range.
  always_comb begin
    f_pop = '0;
    for (int i = 0; i < M; i++) f_pop = f_pop + FW'(f_next[i]);
    cnt_sum = SUMW'(flip_count) + SUMW'(f_pop);
  end

  // Saturating flip counter; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst) begin
      flip_count <= '0;
    end else if (clear_count) begin
      flip_count <= '0;
    end else if (s1_adv) begin
      flip_count <= (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_mecanismo_flipping_pipeline.sv
// Directed bench: a vector table of single beats through a 32-bit-counter
// instance, a backpressure stream, and counter/reset sequences on a
// 4-bit-counter instance.
module tb_mecanismo_flipping_pipeline;
  logic        clk = 1'b0;
  logic        rst, rst_b, clr_a, clr_b;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] fb;
    logic [15:0] a0, a1;
    logic [15:0] o0, o1;
    logic [15:0] f;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl [11];

  mecanismo_flipping_if #(.N(16), .M(16)) bus_a ();
  mecanismo_flipping_if #(.N(16), .M(16)) bus_b ();

  mecanismo_flipping_pipeline #(.N(16), .M(16), .THRESH(8), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave), .clear_count(clr_a), .flip_count(cnt_a)
  );

  mecanismo_flipping_pipeline #(.N(16), .M(16), .THRESH(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b.slave), .clear_count(clr_b), .flip_count(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [1:0] m, input logic [15:0] fb,
                         input logic [15:0] a0, input logic [15:0] a1);
    bus_a.mode = m;
    bus_a.input_f_bits = fb;
    for (int i = 0; i < 16; i++) bus_a.input_activaciones[i] = 16'h0000;
    bus_a.input_activaciones[0] = a0;
    bus_a.input_activaciones[1] = a1;
  endtask

  task automatic drive_b(input logic [1:0] m, input logic [15:0] all, input logic [15:0] a0);
    bus_b.mode = m;
    bus_b.input_f_bits = 16'h0000;
    for (int i = 0; i < 16; i++) bus_b.input_activaciones[i] = all;
    bus_b.input_activaciones[0] = a0;
  endtask

  // One beat on instance A: accept, then out_valid low after the capture
  // edge and high after the following edge.
  task automatic send_a(input logic [1:0] m, input logic [15:0] fb,
                        input logic [15:0] a0, input logic [15:0] a1);
    int n = 0;
    drive_a(m, fb, a0, a1);
    bus_a.in_valid = 1'b1;
    while (!bus_a.in_ready && n < 20) begin tick(); n++; end
    if (n >= 20) chk("accept_timeout_a", 64'd0, 64'd1);
    tick();
    bus_a.in_valid = 1'b0;
    chk("lat_after_capture", 64'(bus_a.out_valid), 64'd0);
    tick();
    chk("lat_out_valid", 64'(bus_a.out_valid), 64'd1);
  endtask

  initial begin
    logic [15:0] bp_in  [5];
    logic [15:0] bp_out [5];
    logic [15:0] bp_f   [5];
    int          ii, oi;
    logic        stalled, saw_drop, acc;
    logic [15:0] prev_d, prev_f;

    tbl[0]  = '{2'b00, 16'h0000, 16'h00FF, 16'h0000, 16'h00FF, 16'h0000, 16'h0000, 32'd0};
    tbl[1]  = '{2'b01, 16'h0001, 16'h1234, 16'hA5A5, 16'hEDCB, 16'hA5A5, 16'h0001, 32'd1};
    tbl[2]  = '{2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 32'd1};
    tbl[3]  = '{2'b10, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 32'd2};
    tbl[4]  = '{2'b10, 16'h0000, 16'h00FF, 16'h0000, 16'h00FF, 16'h0000, 16'h0000, 32'd2};
    tbl[5]  = '{2'b10, 16'h0000, 16'h0F0F, 16'h0000, 16'h0F0F, 16'h0000, 16'h0000, 32'd2};
    tbl[6]  = '{2'b10, 16'h0000, 16'hF0F0, 16'h0000, 16'h0F0F, 16'h0000, 16'h0001, 32'd3};
    tbl[7]  = '{2'b11, 16'h0000, 16'h01FF, 16'h00FF, 16'hFE00, 16'h00FF, 16'h0001, 32'd4};
    tbl[8]  = '{2'b11, 16'h0000, 16'h00FF, 16'h01FF, 16'h00FF, 16'hFE00, 16'h0002, 32'd5};
    tbl[9]  = '{2'b10, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0002, 32'd6};
    tbl[10] = '{2'b01, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'd22};

    bp_in  = '{16'h0001, 16'hFFFF, 16'h0F0F, 16'h7FFF, 16'h0003};
    bp_out = '{16'h0001, 16'h0000, 16'h0F0F, 16'h8000, 16'h0003};
    bp_f   = '{16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'h0000};

    rst = 1'b1; rst_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
    drive_a(2'b00, 16'h0000, 16'h0000, 16'h0000);
    drive_b(2'b00, 16'h0000, 16'h0000);
    bus_a.in_valid = 1'b1;
    bus_b.in_valid = 1'b0;
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_in_ready", 64'(bus_a.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("rst_data", 64'(bus_a.salida_activaciones[0]), 64'd0);
    chk("rst_f", 64'(bus_a.salida_f_bits), 64'd0);
    chk("rst_count", 64'(cnt_a), 64'd0);
    bus_a.in_valid = 1'b0;
    rst = 1'b0; rst_b = 1'b0;
    tick();

    // Vector table, one beat at a time
    for (int t = 0; t < 11; t++) begin
      send_a(tbl[t].mode, tbl[t].fb, tbl[t].a0, tbl[t].a1);
      chk("tbl_lane0", 64'(bus_a.salida_activaciones[0]), 64'(tbl[t].o0));
      chk("tbl_lane1", 64'(bus_a.salida_activaciones[1]), 64'(tbl[t].o1));
      chk("tbl_f", 64'(bus_a.salida_f_bits), 64'(tbl[t].f));
      chk("tbl_count", 64'(cnt_a), 64'(tbl[t].cnt));
    end
    tick();
    chk("drain_out_valid", 64'(bus_a.out_valid), 64'd0);

    // Backpressure: 5 ones-min beats, out_ready low for the first 3 cycles
    ii = 0; oi = 0; stalled = 1'b0; saw_drop = 1'b0; prev_d = '0; prev_f = '0;
    for (int cyc = 0; cyc < 40 && oi < 5; cyc++) begin
      bus_a.out_ready = (cyc >= 3);
      if (ii < 5) begin
        drive_a(2'b11, 16'h0000, bp_in[ii], 16'h0000);
        bus_a.in_valid = 1'b1;
      end else begin
        bus_a.in_valid = 1'b0;
      end
      #1;
      if (ii < 5 && !bus_a.in_ready) saw_drop = 1'b1;
      if (stalled) begin
        chk("bp_hold_data", 64'(bus_a.salida_activaciones[0]), 64'(prev_d));
        chk("bp_hold_f", 64'(bus_a.salida_f_bits), 64'(prev_f));
      end
      stalled = bus_a.out_valid && !bus_a.out_ready;
      prev_d  = bus_a.salida_activaciones[0];
      prev_f  = bus_a.salida_f_bits;
      if (bus_a.out_valid && bus_a.out_ready) begin
        chk("bp_order_data", 64'(bus_a.salida_activaciones[0]), 64'(bp_out[oi]));
        chk("bp_order_f", 64'(bus_a.salida_f_bits), 64'(bp_f[oi]));
        oi++;
      end
      acc = bus_a.in_valid && bus_a.in_ready;
      @(posedge clk);
      if (acc) ii++;
      #1;
    end
    bus_a.in_valid = 1'b0;
    bus_a.out_ready = 1'b1;
    chk("bp_beats_out", 64'(oi), 64'd5);
    chk("bp_in_ready_drop", 64'(saw_drop), 64'd1);
    chk("bp_flip_count", 64'(cnt_a), 64'd24);

    // Saturation: 16 flips into a 4-bit counter
    drive_b(2'b11, 16'hFFFF, 16'hFFFF);
    bus_b.in_valid = 1'b1;
    tick();
    bus_b.in_valid = 1'b0;
    tick();
    chk("sat_out_valid", 64'(bus_b.out_valid), 64'd1);
    chk("sat_lane0", 64'(bus_b.salida_activaciones[0]), 64'd0);
    chk("sat_f", 64'(bus_b.salida_f_bits), 64'hFFFF);
    chk("sat_count", 64'(cnt_b), 64'd15);

    // Clear in the same cycle as a flipping load
    tick();
    clr_b = 1'b1;
    bus_b.in_valid = 1'b1;
    tick();
    bus_b.in_valid = 1'b0;
    tick();
    clr_b = 1'b0;
    chk("clr_out_valid", 64'(bus_b.out_valid), 64'd1);
    chk("clr_count", 64'(cnt_b), 64'd0);

    // Reset mid-stream: X in S2 (history 00FF), Y in S1, then rst
    tick();
    drive_b(2'b00, 16'h0000, 16'h00FF);
    bus_b.in_valid = 1'b1;
    tick();
    drive_b(2'b11, 16'hFFFF, 16'hFFFF);
    tick();
    bus_b.in_valid = 1'b0;
    chk("mid_x_valid", 64'(bus_b.out_valid), 64'd1);
    chk("mid_x_data", 64'(bus_b.salida_activaciones[0]), 64'h00FF);
    rst_b = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(bus_b.in_ready), 64'd0);
    tick();
    chk("mid_rst_out_valid", 64'(bus_b.out_valid), 64'd0);
    chk("mid_rst_data", 64'(bus_b.salida_activaciones[0]), 64'd0);
    rst_b = 1'b0;
    repeat (3) tick();
    chk("mid_no_ghost", 64'(bus_b.out_valid), 64'd0);
    chk("mid_in_ready", 64'(bus_b.in_ready), 64'd1);

    // Cleared history: 01FF vs 0 is distance 9 and flips (vs 00FF it would not)
    drive_b(2'b10, 16'h0000, 16'h01FF);
    bus_b.in_valid = 1'b1;
    tick();
    bus_b.in_valid = 1'b0;
    tick();
    chk("hist_clr_valid", 64'(bus_b.out_valid), 64'd1);
    chk("hist_clr_data", 64'(bus_b.salida_activaciones[0]), 64'hFE00);
    chk("hist_clr_f", 64'(bus_b.salida_f_bits), 64'h0001);
    chk("hist_clr_count", 64'(cnt_b), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
